// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter and its
// round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // ceil(log2(value)), never less than 1 so single-bit fields stay legal
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping at N. Shared with the read-side arbiter.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW:0] cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers;
// each accepted beat is written as {grant_id, payload}.
//
// state | meaning
// IDLE  | no owner; picks next requester from rr_ptr (one bubble per grant)
// GRANT | grant_id owns the write port until last, cap, or a valid gap
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int ID_WIDTH  = clog2_min1(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_wr_en,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy
);

  localparam int CNT_WIDTH = clog2_min1(MAX_BURST + 1);

  arb_state_t           state, state_nxt;
  logic [ID_WIDTH-1:0]  grant_nxt;
  logic [ID_WIDTH-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CNT_WIDTH-1:0] beat_cnt, beat_cnt_nxt;

  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  valid_g;
  logic                  last_g;
  logic [DATA_WIDTH-1:0] data_g;
  logic                  xfer;
  logic                  burst_done;
  logic [ID_WIDTH-1:0]   ptr_after;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  assign busy    = (state == GRANT);
  assign valid_g = req_valid[grant_id];
  assign last_g  = req_last[grant_id];
  assign data_g  = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign xfer    = busy & ~fifo_full & valid_g;

  assign burst_done = last_g | (beat_cnt == CNT_WIDTH'(MAX_BURST - 1));
  assign ptr_after  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (busy && !fifo_full) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Payload passes straight through; din is zeroed when not writing
  assign fifo_wr_en = xfer;
  assign fifo_din   = xfer ? {grant_id, data_g} : '0;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_id;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = GRANT;
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!valid_g) begin
          // a valid gap always gives the port up, even while the FIFO is full
          state_nxt    = IDLE;
          rr_ptr_nxt   = ptr_after;
          beat_cnt_nxt = '0;
        end else if (xfer) begin
          if (burst_done) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = ptr_after;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int IW  = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [IW+DW-1:0] fifo_din;
  logic [IW-1:0]   grant_id;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic        e_busy;
    logic [3:0]  e_ready;
    logic        e_wr;
    logic [11:0] e_din;
  } vec_t;

  vec_t tbl[18];

  // behavioural model state
  bit m_busy;
  int m_gid;
  int m_ptr;
  int m_beats;

  function automatic logic [31:0] pk(input logic [7:0] b3, b2, b1, b0);
    return {b3, b2, b1, b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, l, input logic [31:0] d, input logic f);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    fifo_full = f;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'h0, 4'h0, 32'h0, 1'b0);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_din", 32'(fifo_din), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    @(negedge clk);
    rst = 1'b0;
    m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0;
    tick();
  endtask

  // one cycle of the model: check DUT outputs for these inputs, then advance
  task automatic model_cycle(input logic [3:0] v, l, input logic [31:0] d, input logic f,
                             output bit xfer_o, output int gid_o);
    bit xfer;
    logic [3:0] e_rdy;
    logic [11:0] e_din;
    e_rdy = 4'h0;
    if (m_busy && !f) e_rdy[m_gid] = 1'b1;
    xfer  = m_busy && !f && v[m_gid];
    e_din = xfer ? {2'(m_gid), d[m_gid*8 +: 8]} : 12'h0;
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_ready", 32'(req_ready), 32'(e_rdy));
    chk("m_wr_en", 32'(fifo_wr_en), 32'(xfer));
    chk("m_din", 32'(fifo_din), 32'(e_din));
    if (m_busy) chk("m_grant_id", 32'(grant_id), 32'(m_gid));
    xfer_o = xfer;
    gid_o  = m_gid;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (v[(m_ptr + k) % N]) begin
          m_gid   = (m_ptr + k) % N;
          m_busy  = 1;
          m_beats = 0;
          break;
        end
      end
    end else if (!v[m_gid]) begin
      m_busy = 0; m_ptr = (m_gid + 1) % N; m_beats = 0;
    end else if (xfer) begin
      m_beats++;
      if (l[m_gid] || m_beats == MB) begin
        m_busy = 0; m_ptr = (m_gid + 1) % N; m_beats = 0;
      end
    end
  endtask

  initial begin
    int rr_got[$];
    int rr_exp[6] = '{0, 1, 3, 0, 1, 3};
    int plen[N];
    logic [7:0] pdat[N];
    logic [3:0] v, l;
    logic [31:0] d;
    logic f;
    bit xf;
    int g;

    rst = 1'b1;
    drive(4'h0, 4'h0, 32'h0, 1'b0);

    tbl[0]  = '{4'h4, 4'h0, pk(0, 8'h11, 0, 0), 0, 0, 4'h0, 0, 12'h000};
    tbl[1]  = '{4'h4, 4'h0, pk(0, 8'h11, 0, 0), 0, 1, 4'h4, 1, 12'h211};
    tbl[2]  = '{4'h4, 4'h0, pk(0, 8'h22, 0, 0), 0, 1, 4'h4, 1, 12'h222};
    tbl[3]  = '{4'h4, 4'h4, pk(0, 8'h33, 0, 0), 0, 1, 4'h4, 1, 12'h233};
    tbl[4]  = '{4'h9, 4'h9, pk(8'h44, 0, 0, 8'h55), 0, 0, 4'h0, 0, 12'h000};
    tbl[5]  = '{4'h9, 4'h9, pk(8'h44, 0, 0, 8'h55), 0, 1, 4'h8, 1, 12'h344};
    tbl[6]  = '{4'h1, 4'h1, pk(0, 0, 0, 8'h55), 0, 0, 4'h0, 0, 12'h000};
    tbl[7]  = '{4'h1, 4'h1, pk(0, 0, 0, 8'h55), 0, 1, 4'h1, 1, 12'h055};
    tbl[8]  = '{4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 0, 12'h000};
    tbl[9]  = '{4'h1, 4'h0, pk(0, 0, 0, 8'h01), 0, 0, 4'h0, 0, 12'h000};
    tbl[10] = '{4'h1, 4'h0, pk(0, 0, 0, 8'h01), 0, 1, 4'h1, 1, 12'h001};
    tbl[11] = '{4'h1, 4'h0, pk(0, 0, 0, 8'h02), 0, 1, 4'h1, 1, 12'h002};
    tbl[12] = '{4'h1, 4'h0, pk(0, 0, 0, 8'h03), 0, 1, 4'h1, 1, 12'h003};
    tbl[13] = '{4'h1, 4'h0, pk(0, 0, 0, 8'h04), 0, 1, 4'h1, 1, 12'h004};
    tbl[14] = '{4'h1, 4'h0, pk(0, 0, 0, 8'h05), 0, 0, 4'h0, 0, 12'h000};
    tbl[15] = '{4'h1, 4'h0, pk(0, 0, 0, 8'h05), 0, 1, 4'h1, 1, 12'h005};
    tbl[16] = '{4'h1, 4'h1, pk(0, 0, 0, 8'h06), 0, 1, 4'h1, 1, 12'h006};
    tbl[17] = '{4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 0, 12'h000};

    // vector table: single requester, rr_ptr wrap, burst cap
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].f);
      #2;
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_wr_en", i), 32'(fifo_wr_en), 32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_din", i), 32'(fifo_din), 32'(tbl[i].e_din));
      tick();
    end

    // round-robin among 0, 1, 3 with single-beat bursts
    do_reset();
    drive(4'hB, 4'hB, pk(8'h33, 0, 8'h11, 8'h00), 0);
    for (int c = 0; c < 40 && rr_got.size() < 6; c++) begin
      #2;
      if (fifo_wr_en) rr_got.push_back(int'(grant_id));
      tick();
    end
    chk("rr_count", 32'(rr_got.size()), 6);
    for (int i = 0; i < rr_got.size() && i < 6; i++) begin
      chk($sformatf("rr_order%0d", i), 32'(rr_got[i]), 32'(rr_exp[i]));
      if (i > 0) chk($sformatf("rr_no_repeat%0d", i), 32'(rr_got[i] != rr_got[i-1]), 1);
    end

    // backpressure mid-burst on requester 1
    do_reset();
    drive(4'h2, 4'h0, pk(0, 0, 8'h10, 0), 0);
    #2 chk("bp_bubble", 32'(busy), 0);
    tick();
    #2 chk("bp_first", 32'(fifo_din), 12'h110);
    tick();
    drive(4'h2, 4'h0, pk(0, 0, 8'hAA, 0), 1);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("bp_stall_ready", 32'(req_ready), 0);
      chk("bp_stall_wr_en", 32'(fifo_wr_en), 0);
      chk("bp_stall_busy", 32'(busy), 1);
      tick();
    end
    fifo_full = 1'b0;
    #2 chk("bp_held_beat", 32'(fifo_din), 12'h1AA);
    chk("bp_held_wr_en", 32'(fifo_wr_en), 1);
    tick();
    req_data = pk(0, 0, 8'hBB, 0);
    #2 chk("bp_beat3", 32'(fifo_din), 12'h1BB);
    tick();
    req_data = pk(0, 0, 8'hCC, 0);
    #2 chk("bp_beat4", 32'(fifo_din), 12'h1CC);
    tick();
    req_data = pk(0, 0, 8'hDD, 0);
    #2 chk("bp_cap_release", 32'(busy), 0);
    chk("bp_cap_no_write", 32'(fifo_wr_en), 0);
    tick();

    // valid gap on requester 3 releases; rr_ptr wraps to 0
    do_reset();
    drive(4'h8, 4'h0, pk(8'h77, 0, 0, 0), 0);
    #2 chk("gap_bubble", 32'(busy), 0);
    tick();
    #2 chk("gap_beat", 32'(fifo_din), 12'h377);
    tick();
    req_valid = 4'h0;
    #2 chk("gap_no_write", 32'(fifo_wr_en), 0);
    tick();
    drive(4'h9, 4'h0, pk(8'h78, 0, 0, 8'h05), 0);
    #2 chk("gap_idle", 32'(busy), 0);
    chk("gap_idle_no_write", 32'(fifo_wr_en), 0);
    tick();
    #2 chk("gap_next_grant", 32'(grant_id), 0);
    chk("gap_next_din", 32'(fifo_din), 12'h005);
    tick();

    // asynchronous reset during requester 2's second beat
    do_reset();
    drive(4'h4, 4'h0, pk(0, 8'h21, 0, 0), 0);
    tick();
    #2 chk("arst_beat1", 32'(fifo_din), 12'h221);
    tick();
    req_data = pk(0, 8'h22, 0, 0);
    #1 chk("arst_beat2_wr", 32'(fifo_wr_en), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(req_ready), 0);
    chk("arst_wr_en", 32'(fifo_wr_en), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'h6, 4'h0, pk(0, 8'h22, 8'h31, 0), 0);
    tick();
    #1 chk("arst_regrant_id", 32'(grant_id), 1);
    chk("arst_regrant_din", 32'(fifo_din), 12'h131);

    // randomized producers against the model
    do_reset();
    for (int i = 0; i < N; i++) begin
      plen[i] = 0;
      pdat[i] = 8'h0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (plen[i] == 0 && $urandom_range(0, 3) == 0) begin
          plen[i] = $urandom_range(1, 6);
          pdat[i] = 8'($urandom);
        end
        if (m_busy && m_gid == i && plen[i] > 0 && $urandom_range(0, 15) == 0) plen[i] = 0;
        v[i] = (plen[i] > 0);
        l[i] = (plen[i] == 1);
        d[i*8 +: 8] = pdat[i];
      end
      f = ($urandom_range(0, 3) == 0);
      drive(v, l, d, f);
      #2;
      model_cycle(v, l, d, f, xf, g);
      if (xf) begin
        plen[g]--;
        pdat[g] = 8'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ requesters.
- Each requester presents beats over a valid/ready handshake.
- The arbiter grants one requester at a time for a burst of up to MAX_BURST beats.
- Each accepted beat is written into the FIFO, tagged with the requester ID, so the read side can demultiplex.
- Sits between producer blocks and the FIFO's wr_en/din/full pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, payload width per beat.
- MAX_BURST, 4, maximum beats per grant before forced release (1..255).
- ID_WIDTH, derived: clog2(NUM_REQ), minimum 1. Not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester end-of-burst marker, qualified by valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_din  out  ID_WIDTH+DATA_WIDTH  {grant_id, payload}.
- grant_id  out  ID_WIDTH  currently granted requester; valid while busy=1.
- busy  out  1  1 while in GRANT state.

Behaviour:
- Reset (asynchronous, active-high), applied immediately:
  - state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0.
  - busy=0, req_ready=0, fifo_wr_en=0, fifo_din=0.
- State register, IDLE:
  - If any req_valid is high, select the first set bit searching upward from rr_ptr with wraparound.
  - Register the selection into grant_id, clear beat_cnt, and move to GRANT.
  - This costs one bubble cycle per grant. No beat is accepted in IDLE.
- req_ready[i] (combinational from registered state): 1 only when state=GRANT, i=grant_id and fifo_full=0.
- Transfer: xfer = req_valid[grant_id] & req_ready[grant_id].
  - fifo_wr_en = xfer.
  - fifo_din = {grant_id, req_data[grant_id]} when xfer, else 0.
  - Payload passes straight through; no added latency.
- GRANT, on xfer:
  - beat_cnt increments.
  - If req_last[grant_id]=1 or beat_cnt=MAX_BURST-1: go to IDLE, set rr_ptr=(grant_id+1) mod NUM_REQ, clear beat_cnt.
- GRANT with req_valid[grant_id]=0: the burst ends. Go to IDLE next cycle with the same rr_ptr update and no write. A valid gap always releases the grant.
- GRANT with fifo_full=1 and valid=1: stall. Stay in GRANT, req_ready=0, no write, beat_cnt holds. No timeout.
- Other requesters' valid/last are ignored during GRANT. Their requests wait and must be held stable by the producers.
- rr_ptr wraps from NUM_REQ-1 to 0. Whenever two or more requesters are persistently active, the same requester never receives consecutive grants.
- Reset mid-burst aborts the grant immediately. Beats already written stay in the FIFO. The producer must replay the rest.
- beat_cnt width is clog2(MAX_BURST+1). Comparisons are unsigned.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum {IDLE, GRANT}.
  - clog2-based ID_WIDTH/count-width helper function.
- One natural sub-module: rr_pick, a combinational round-robin priority search.
  - Inputs: request vector, rr_ptr.
  - Outputs: found, index.
  - Reusable for the matching read-side arbiter.

Test Plan (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4):
- Single requester: req 2 sends 0x11,0x22,0x33 with last on 0x33 and fifo_full=0.
  - Expect 1 bubble cycle, then fifo_wr_en on 3 consecutive cycles.
  - fifo_din = 0x211, 0x222, 0x233; then IDLE, rr_ptr=3.
- Burst cap: req 0 holds valid with no last for 6 beats (0x01..0x06).
  - Expect 0x01..0x04 written, then release.
  - Req 0 is re-granted after a 1-cycle bubble and writes 0x05, 0x06.
- Round-robin: reqs 0, 1, 3 all valid with 1-beat bursts (last=1), starting rr_ptr=0.
  - Grant order 0, 1, 3, 0, 1, 3.
  - grant_id is never repeated back-to-back.
- Backpressure: req 1 mid-burst, fifo_full=1 for 3 cycles.
  - req_ready=0 and fifo_wr_en=0 throughout; beat_cnt unchanged.
  - After full drops, the beat written is the one held (0xAA → fifo_din 0x1AA).
- Valid gap: req 3 sends 1 beat without last, then drops valid.
  - Expect return to IDLE next cycle, rr_ptr=0, no spurious write.
- Async reset mid-burst: assert rst between clock edges during req 2's second beat.
  - busy, req_ready and fifo_wr_en go to 0 immediately, without a clock edge.
  - After release, the first grant goes to the lowest valid index ≥0.
